phase_table_scheduler: RTL and testbench

- Selects the timing table (A/B/C/D) that the intersection phase FSM uses on each signal cycle.
- Debounces the vehicle sensors SNN/SNS/STH and the pedestrian pushbuttons PNN/PNS/PTH, and latches pedestrian requests until they are served.
- Commits a new table only at cycle boundaries. The table never changes mid-cycle, and a starvation bound forces the balanced table A periodically.
- Sits between the raw field inputs and the phase FSM's table-select input.

---
 rtl/traffic_pkg.sv | 36 +++
 rtl/input_debouncer.sv | 47 ++++
 rtl/phase_table_scheduler.sv | 174 +++++++++++++++++
 tb/tb_phase_table_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection timing-table scheduler.
// Table codes, scheduler states and field-input indices live here.
package traffic_pkg;

    localparam logic [1:0] TABLE_A = 2'd0;
    localparam logic [1:0] TABLE_B = 2'd1;
    localparam logic [1:0] TABLE_C = 2'd2;
    localparam logic [1:0] TABLE_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2
    } sched_state_t;

    localparam int IDX_SNN    = 0;
    localparam int IDX_SNS    = 1;
    localparam int IDX_STH    = 2;
    localparam int IDX_PNN    = 3;
    localparam int IDX_PNS    = 4;
    localparam int IDX_PTH    = 5;
    localparam int NUM_INPUTS = 6;

    // A single active sensor picks its dedicated table; anything else is balanced.
    function automatic logic [1:0] candidate_table(input logic snn, input logic sns, input logic sth);
        logic [1:0] t;
        case ({sth, sns, snn})
            3'b100:  t = TABLE_B;
            3'b001:  t = TABLE_C;
            3'b010:  t = TABLE_D;
            default: t = TABLE_A;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a ms-tick debounce counter for one field input.
// The level flips only after DEBOUNCE_MS consecutive ticks at the new value.
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any return to the accepted level restarts the qualification window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == CW'(DEBOUNCE_MS - 1)) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/phase_table_scheduler.sv
// Picks the timing table for each signal cycle from debounced field inputs.
// Optional macro PED_PRIORITY_EN: a pending pedestrian request forces table A.
module phase_table_scheduler
    import traffic_pkg::*;
#(
    parameter int CLK_HZ      = 10000,
    parameter int DEBOUNCE_MS = 20,
    parameter int MAX_REPEAT  = 3
) (
    input  logic       CLK,
    input  logic       reset_general,
    input  logic       enable_general,
    input  logic       SNN,
    input  logic       SNS,
    input  logic       STH,
    input  logic       PNN,
    input  logic       PNS,
    input  logic       PTH,
    input  logic       cycle_start,
    input  logic       served_N,
    input  logic       served_TH,
    output logic [1:0] tabla,
    output logic       tabla_valid,
    output logic       table_change,
    output logic       ped_pending_N,
    output logic       ped_pending_TH
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW       = (MAX_REPEAT > 0) ? $clog2(MAX_REPEAT + 1) : 1;

    logic [PW-1:0]         r_presc;
    logic                  w_tick;
    logic [NUM_INPUTS-1:0] w_raw;
    logic [NUM_INPUTS-1:0] w_deb;
    logic [2:0]            r_ped_prev;
    logic                  w_rise_n;
    logic                  w_rise_th;
    logic                  r_pend_n;
    logic                  r_pend_th;

    sched_state_t          r_state;
    logic [1:0]            r_tabla;
    logic                  r_valid;
    logic                  r_change;
    logic [RW-1:0]         r_repeat;

    logic [1:0]            w_cand;
    logic [1:0]            w_next;
    logic [RW-1:0]         w_next_rep;
    logic                  w_force_ped;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge reset_general) begin
        if (!reset_general) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_raw[IDX_SNN] = SNN;
    assign w_raw[IDX_SNS] = SNS;
    assign w_raw[IDX_STH] = STH;
    assign w_raw[IDX_PNN] = PNN;
    assign w_raw[IDX_PNS] = PNS;
    assign w_raw[IDX_PTH] = PTH;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
            input_debouncer #(
                .DEBOUNCE_MS(DEBOUNCE_MS)
            ) u_deb (
                .i_clk  (CLK),
                .i_rst_n(reset_general),
                .i_tick (w_tick),
                .i_raw  (w_raw[gi]),
                .o_level(w_deb[gi])
            );
        end
    endgenerate

    assign w_rise_n  = (w_deb[IDX_PNN] & ~r_ped_prev[0]) | (w_deb[IDX_PNS] & ~r_ped_prev[1]);
    assign w_rise_th = w_deb[IDX_PTH] & ~r_ped_prev[2];

    // Pedestrian latches run independently of enable; a new press beats a served pulse.
    always_ff @(posedge CLK or negedge reset_general) begin
        if (!reset_general) begin
            r_ped_prev <= '0;
            r_pend_n   <= 1'b0;
            r_pend_th  <= 1'b0;
        end else begin
            r_ped_prev <= {w_deb[IDX_PTH], w_deb[IDX_PNS], w_deb[IDX_PNN]};
            if (w_rise_n)       r_pend_n <= 1'b1;
            else if (served_N)  r_pend_n <= 1'b0;
            if (w_rise_th)      r_pend_th <= 1'b1;
            else if (served_TH) r_pend_th <= 1'b0;
        end
    end

    always_comb begin
        w_cand     = candidate_table(w_deb[IDX_SNN], w_deb[IDX_SNS], w_deb[IDX_STH]);
        w_next     = w_cand;
        w_next_rep = '0;
`ifdef PED_PRIORITY_EN
        w_force_ped = r_pend_n | r_pend_th;
`else
        w_force_ped = 1'b0;
`endif
        if (w_force_ped) begin
            w_next     = TABLE_A;
            w_next_rep = '0;
        end else if ((r_repeat == RW'(MAX_REPEAT)) && (w_cand == r_tabla)) begin
            // Starvation guard: give the balanced table one cycle.
            w_next     = TABLE_A;
            w_next_rep = '0;
        end else if (w_cand != TABLE_A) begin
            if (w_cand == r_tabla) begin
                w_next_rep = (r_repeat == RW'(MAX_REPEAT)) ? r_repeat : r_repeat + RW'(1);
            end else begin
                w_next_rep = RW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_general) begin
        if (!reset_general) begin
            r_state  <= S_IDLE;
            r_tabla  <= TABLE_A;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
            r_repeat <= '0;
        end else begin
            r_change <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tabla  <= TABLE_A;
                    r_valid  <= 1'b0;
                    r_repeat <= '0;
                    if (enable_general) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cycle_start) begin
                        r_state <= S_EVAL;
                    end else if (!enable_general) begin
                        r_state  <= S_IDLE;
                        r_tabla  <= TABLE_A;
                        r_valid  <= 1'b0;
                        r_repeat <= '0;
                    end
                end
                S_EVAL: begin
                    r_tabla  <= w_next;
                    r_valid  <= 1'b1;
                    r_change <= (w_next != r_tabla);
                    r_repeat <= w_next_rep;
                    r_state  <= S_WAIT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tabla          = r_tabla;
    assign tabla_valid    = r_valid;
    assign table_change   = r_change;
    assign ped_pending_N  = r_pend_n;
    assign ped_pending_TH = r_pend_th;

endmodule

// File: tb/tb_phase_table_scheduler.sv
// Self-checking bench for phase_table_scheduler: directed scenarios then random cycles
// against a cycle-level table/latch model. Honours PED_PRIORITY_EN when defined.
module tb_phase_table_scheduler;

    localparam int MAXR = 3;

    logic       CLK = 1'b0;
    logic       reset_general = 1'b0;
    logic       enable_general = 1'b0;
    logic [2:0] raw_sens = 3'b000;   // {STH, SNS, SNN}
    logic [2:0] raw_btn = 3'b000;    // {PTH, PNS, PNN}
    logic       cycle_start = 1'b0;
    logic       served_N = 1'b0;
    logic       served_TH = 1'b0;
    logic [1:0] tabla;
    logic       tabla_valid;
    logic       table_change;
    logic       ped_pending_N;
    logic       ped_pending_TH;

    int ncyc;
    int n_chk = 0;
    int n_err = 0;

    logic [1:0] m_tabla = 2'd0;
    logic       m_valid = 1'b0;
    int         m_rep = 0;
    logic       m_pend_n = 1'b0;
    logic       m_pend_th = 1'b0;
    logic [2:0] m_sens = 3'b000;

    phase_table_scheduler #(
        .CLK_HZ(10000), .DEBOUNCE_MS(20), .MAX_REPEAT(MAXR)
    ) dut (
        .CLK(CLK), .reset_general(reset_general), .enable_general(enable_general),
        .SNN(raw_sens[0]), .SNS(raw_sens[1]), .STH(raw_sens[2]),
        .PNN(raw_btn[0]), .PNS(raw_btn[1]), .PTH(raw_btn[2]),
        .cycle_start(cycle_start), .served_N(served_N), .served_TH(served_TH),
        .tabla(tabla), .tabla_valid(tabla_valid), .table_change(table_change),
        .ped_pending_N(ped_pending_N), .ped_pending_TH(ped_pending_TH)
    );

    always #5 CLK = ~CLK;

    // Clock edges since reset release; ms ticks land on edges where this is a multiple of 10.
    always @(posedge CLK or negedge reset_general) begin
        if (!reset_general) ncyc <= 0;
        else                ncyc <= ncyc + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_tabla = 2'd0;
        m_valid = 1'b0;
        m_rep   = 0;
    endtask

    task automatic model_eval(output logic [1:0] t, output logic c);
        logic [1:0] cand;
        logic       force_ped;
        case (m_sens)
            3'b100:  cand = 2'd1;
            3'b001:  cand = 2'd2;
            3'b010:  cand = 2'd3;
            default: cand = 2'd0;
        endcase
`ifdef PED_PRIORITY_EN
        force_ped = m_pend_n | m_pend_th;
`else
        force_ped = 1'b0;
`endif
        if (force_ped) begin
            t = 2'd0; m_rep = 0;
        end else if (m_rep == MAXR && cand == m_tabla) begin
            t = 2'd0; m_rep = 0;
        end else begin
            t = cand;
            if (cand == 2'd0)          m_rep = 0;
            else if (cand == m_tabla)  m_rep = (m_rep < MAXR) ? m_rep + 1 : MAXR;
            else                       m_rep = 1;
        end
        c = (t != m_tabla);
        m_tabla = t;
        m_valid = 1'b1;
    endtask

    task automatic do_cycle(input string tag);
        logic [1:0] prev;
        logic [1:0] et;
        logic       ec;
        prev = m_tabla;
        model_eval(et, ec);
        cycle_start = 1'b1;
        @(posedge CLK); #1;
        cycle_start = 1'b0;
        chk({tag, "_hold"}, tabla, prev);
        @(posedge CLK); #1;
        chk({tag, "_tabla"}, tabla, et);
        chk({tag, "_chg"}, table_change, ec);
        chk({tag, "_valid"}, tabla_valid, 1);
        chk({tag, "_pendN"}, ped_pending_N, m_pend_n);
        chk({tag, "_pendTH"}, ped_pending_TH, m_pend_th);
        @(posedge CLK); #1;
        chk({tag, "_chg_end"}, table_change, 0);
    endtask

    task automatic pulse_served(input logic n, input logic th);
        served_N  = n;
        served_TH = th;
        @(posedge CLK); #1;
        served_N  = 1'b0;
        served_TH = 1'b0;
        if (n)  m_pend_n  = 1'b0;
        if (th) m_pend_th = 1'b0;
        chk("served_pendN", ped_pending_N, m_pend_n);
        chk("served_pendTH", ped_pending_TH, m_pend_th);
    endtask

    initial begin
        int seq[5] = '{1, 1, 1, 0, 1};
        int m0, t1, e, g;
        logic [2:0] pat;
        logic [2:0] btn;
        int idx;

        clk_n(3);
        chk("rst_tabla", tabla, 0);
        chk("rst_valid", tabla_valid, 0);
        chk("rst_chg", table_change, 0);
        chk("rst_pendN", ped_pending_N, 0);
        chk("rst_pendTH", ped_pending_TH, 0);

        reset_general  = 1'b1;
        enable_general = 1'b1;
        clk_n(2);

        raw_sens = 3'b100;
        clk_n(250);
        m_sens = 3'b100;
        do_cycle("sth");
        chk("sth_is_B", tabla, 1);

        raw_btn = 3'b001;
        clk_n(300);
        raw_btn = 3'b000;
        clk_n(250);
        m_pend_n = 1'b1;
        chk("pnn_latched", ped_pending_N, 1);

        // Reset asserted while the scheduler is evaluating.
        cycle_start = 1'b1;
        @(posedge CLK); #1;
        cycle_start   = 1'b0;
        reset_general = 1'b0;
        #1;
        chk("rst_mid_tabla", tabla, 0);
        chk("rst_mid_valid", tabla_valid, 0);
        chk("rst_mid_pendN", ped_pending_N, 0);
        raw_sens = 3'b000;
        @(posedge CLK); #1;
        reset_general = 1'b1;
        model_reset();
        m_pend_n = 1'b0;
        m_sens   = 3'b000;
        clk_n(1);
        do_cycle("post_rst");

        raw_sens = 3'b100;
        clk_n(100);
        raw_sens = 3'b000;
        clk_n(30);
        do_cycle("glitch");
        chk("glitch_is_A", tabla, 0);

        raw_sens = 3'b100;
        clk_n(250);
        m_sens = 3'b100;
        for (int i = 0; i < 5; i++) begin
            do_cycle($sformatf("rep%0d", i));
            chk($sformatf("rep%0d_seq", i), tabla, seq[i]);
            clk_n(20);
        end

        raw_btn = 3'b001;
        clk_n(300);
        raw_btn = 3'b000;
        clk_n(250);
        m_pend_n = 1'b1;
        do_cycle("ped");
`ifdef PED_PRIORITY_EN
        chk("ped_forces_A", tabla, 0);
`else
        chk("ped_keeps_B", tabla, 1);
`endif

        // Served pulse aligned with the latch-set edge of a fresh debounced PNN rise.
        m0 = ncyc;
        raw_btn = 3'b001;
        t1 = m0 + 3;
        while (t1 % 10 != 0) t1++;
        e = t1 + 190;
        g = 0;
        while (ncyc != e && g < 1000) begin
            @(posedge CLK); #1;
            g++;
        end
        if (g >= 1000) chk("setwin_reach", ncyc, e);
        served_N = 1'b1;
        @(posedge CLK); #1;
        served_N = 1'b0;
        chk("set_wins", ped_pending_N, 1);
        raw_btn = 3'b000;
        clk_n(250);
        pulse_served(1'b1, 1'b0);

        raw_sens = 3'b001;
        for (int k = 0; k < 10; k++) begin
            clk_n(100);
            chk($sformatf("idle_hold%0d", k), tabla, m_tabla);
        end
        m_sens = 3'b001;
        do_cycle("snn");
        chk("snn_is_C", tabla, 2);

        pat = 3'b001;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 0) pat = 3'($urandom_range(0, 7));
            btn = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            raw_sens = pat;
            raw_btn  = btn;
            clk_n(300);
            m_sens = pat;
            if (btn[0] | btn[1]) m_pend_n  = 1'b1;
            if (btn[2])          m_pend_th = 1'b1;
            raw_btn = 3'b000;
            clk_n(250);
            if ($urandom_range(0, 2) == 0)
                pulse_served(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 2);
                raw_sens[idx] = ~raw_sens[idx];
                clk_n($urandom_range(20, 150));
                raw_sens[idx] = ~raw_sens[idx];
                clk_n(20);
            end
            if ($urandom_range(0, 5) == 0) begin
                enable_general = 1'b0;
                clk_n(3);
                chk($sformatf("dis%0d_tabla", it), tabla, 0);
                chk($sformatf("dis%0d_valid", it), tabla_valid, 0);
                model_reset();
                enable_general = 1'b1;
                clk_n(2);
            end
            do_cycle($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
